da2_rx_dual: RTL
================

# da2_rx_dual

Dual-channel receiver/decoder for the Pmod DA2 serial frame: the slave end of the link that `da2_dual` drives. It deserialises two 16-bit frames shifted in parallel on `SDATA[1:0]` under `SYNC`/`SCLK`, then presents the decoded 12-bit values and 2-bit power modes. It also keeps frame and abort statistics. It serves as a loop-back checker for the DA2 transmitter on-chip and as a behavioural DAC model in system benches.

## Interface
- No parameters; frame length fixed at 16 bits, two channels.
- `SCLK` in 1: serial clock. All sampling happens on its falling edge.
- `rst` in 1: asynchronous, active-high reset.
- `SYNC` in 1: frame sync. A high level asynchronously restarts frame reception.
- `SDATA` in 2: serial data, MSB first. Bit 0 is channel 0, bit 1 is channel 1.
- `value0`, `value1` out 12: last completed frame data, bits [11:0].
- `chmode0`, `chmode1` out 2: last completed frame power mode, bits [13:12].
  - 00 enabled, 01 1 kΩ, 10 100 kΩ, 11 High-Z.
- `enabled` out 2: `{chmode1==00, chmode0==00}`.
- `busy` out 1: high in state SHIFT.
- `frame_cnt` out 8: completed frames, wraps.
- `abort_cnt` out 4: aborted frames, saturates at 15.
- `fmt_err` out 1: sticky; a completed frame had a nonzero bit 15 or bit 14 on either lane.

## Operation
- Registers:
  - two 15-bit shift registers;
  - `bitcnt[3:0]`;
  - state in {IDLE, SHIFT, DONE};
  - output registers.
- Reset (`rst`=1), which has priority over everything:
  - state IDLE, `bitcnt`=0, shift registers 0;
  - `value*`=0, `chmode*`=00, `enabled`=11, `busy`=0;
  - `frame_cnt`=0, `abort_cnt`=0, `fmt_err`=0.
- `SYNC` high, asynchronous, ignored while `rst`=1:
  - state becomes SHIFT, `bitcnt`=0, shift registers cleared.
  - While `SYNC` stays high, `SCLK` edges are ignored.
- IDLE and DONE: `SCLK` edges are ignored and all outputs hold.
- SHIFT, on each falling edge of `SCLK` with `SYNC` low:
  - each lane shifts in its `SDATA` bit: `sr <= {sr[13:0], SDATA[i]}`;
  - `bitcnt` increments.
- SHIFT, on the falling edge where `bitcnt`==15 (the 16th bit):
  - form `word_i = {sr_i, SDATA[i]}`;
  - `value_i` <= `word_i[11:0]`, `chmode_i` <= `word_i[13:12]`, both lanes updated atomically;
  - `frame_cnt` increments;
  - `fmt_err` is set if `word0[15:14]` or `word1[15:14]` is nonzero; the frame is still accepted;
  - state becomes DONE and `bitcnt` returns to 0.
- Abort:
  - On a rising edge of `SYNC` while the pre-edge state is SHIFT with `bitcnt`≠0, `abort_cnt` increments, saturating at 15.
  - This counter is clocked by `SYNC` and reset by `rst`.
  - Outputs are unchanged and the new frame proceeds normally.
  - `SYNC` rising in SHIFT with `bitcnt`==0, in IDLE, or in DONE is not an abort.
- `frame_cnt` wraps from 255 to 0.
- `enabled` and `busy` are decoded from registers, so they are glitch-free.

## Timing
- Bit order: bit 15 is sampled at the 1st falling edge after `SYNC` goes low; bit 0 at the 16th.
- Transmitter contract: `da2_dual` presents data on the rising edge of `SCLK`. The receiver samples mid-bit on the falling edge.
- `SCLK` may be stopped before, during, and after a frame; no free-running clock is needed.
- Output latency: `value*`, `chmode*`, `frame_cnt` and `fmt_err` change on the 16th falling edge itself, with no extra cycle.
- `busy` rises asynchronously with `SYNC` and falls on the 16th falling edge.
- Extra `SCLK` edges after the 16th (the transmitter may emit one) are ignored.
- Reset mid-frame discards the partial frame; no abort is counted.
- `rst` and `SYNC` both high: reset wins; the state is SHIFT after `rst` falls only if `SYNC` is still high.
- Consumers in another clock domain must synchronise `frame_cnt` and treat a change as a new-frame event. Gray coding is not required, because updates are at least 16 `SCLK` periods apart.

## Test plan
- Reset and idle:
  - Stimulus: pulse `rst`, then 40 `SCLK` cycles with `SYNC` low.
  - Required: all outputs stay at reset values; `busy`=0; `enabled`=11.
- Single frame:
  - Stimulus: lane 0 = 0x0ABC, lane 1 = 0x3123, driven by `da2_dual` with `chmode0`=00, `value0`=0xABC, `chmode1`=11, `value1`=0x123.
  - Required: `value0`=0xABC, `chmode0`=00, `value1`=0x123, `chmode1`=11, `enabled`=01, `frame_cnt`=1, `fmt_err`=0, `busy`=0.
- Abort:
  - Stimulus: `SYNC`, 7 falling edges, `SYNC`, then a full frame of 0x1555 on both lanes.
  - Required: `abort_cnt`=1, `value0`=`value1`=0x555, `chmode*`=01, `frame_cnt`=1.
- Overrun edges:
  - Stimulus: `SYNC`, then 20 falling edges carrying 0x0FFF followed by four 0 bits.
  - Required: `value0`=0xFFF, `frame_cnt` increments by exactly 1, state DONE.
- Format error:
  - Stimulus: lane 0 frame 0xC000.
  - Required: `fmt_err`=1, `value0`=0x000, `chmode0`=00, frame counted; `fmt_err` remains 1 after a following clean frame and clears only on `rst`.
- Counter limits and reset mid-frame:
  - 256 clean frames: `frame_cnt` returns to 0.
  - 20 aborts: `abort_cnt` holds at 15.
  - `rst` asserted after 9 bits: outputs return to reset values and `abort_cnt`=0.

Source files
------------

// File: rtl/da2_rx_dual_if.sv
// Serial link and decoded-output bundle for the dual-lane DA2 receiver.
//   SYNC               frame sync; a high level restarts frame reception
//   SDATA[1:0]         serial data, MSB first, bit i = channel i
//   value0/value1      last completed frame data, bits [11:0]
//   chmode0/chmode1    last completed frame power mode, bits [13:12]
//   enabled            {chmode1==00, chmode0==00}
//   busy               a frame is being shifted in
//   frame_cnt          completed frames, wraps at 256
//   abort_cnt          aborted frames, saturates at 15
//   fmt_err            sticky; a completed frame had bit 15 or bit 14 set
// master: transmitter / consumer side.  slave: the receiver.
interface da2_rx_dual_if;
    logic        SYNC;
    logic [1:0]  SDATA;
    logic [11:0] value0;
    logic [11:0] value1;
    logic [1:0]  chmode0;
    logic [1:0]  chmode1;
    logic [1:0]  enabled;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic [3:0]  abort_cnt;
    logic        fmt_err;

    modport master (
        output SYNC, SDATA,
        input  value0, value1, chmode0, chmode1, enabled, busy,
               frame_cnt, abort_cnt, fmt_err
    );

    modport slave (
        input  SYNC, SDATA,
        output value0, value1, chmode0, chmode1, enabled, busy,
               frame_cnt, abort_cnt, fmt_err
    );
endinterface

// File: rtl/da2_rx_dual.sv
// Dual-channel Pmod DA2 frame receiver/decoder.
// Deserialises two 16-bit frames shifted in parallel on SDATA[1:0], sampling
// on the falling edge of SCLK, and presents the decoded 12-bit values and
// 2-bit power modes together with frame/abort statistics.
// Ports:
//   SCLK  serial clock, all sampling on its falling edge (may be stopped)
//   rst   asynchronous active-high reset, priority over everything
//   bus   da2_rx_dual_if.slave: SYNC/SDATA in, decoded outputs and stats out
module da2_rx_dual (
    input  logic         SCLK,
    input  logic         rst,
    da2_rx_dual_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [14:0] sr0_q, sr0_d;
    logic [14:0] sr1_q, sr1_d;
    logic        busy_q, busy_d;

    logic [11:0] value0_q, value0_d;
    logic [11:0] value1_q, value1_d;
    logic [1:0]  chmode0_q, chmode0_d;
    logic [1:0]  chmode1_q, chmode1_d;
    logic [1:0]  enabled_q, enabled_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        fmt_err_q, fmt_err_d;
    logic [3:0]  abort_cnt_q;

    logic [15:0] word0, word1;
    logic        sync_set;

    // SYNC acts as an asynchronous restart, masked by reset. Gating it with
    // ~rst also produces a rising edge when rst falls while SYNC is still
    // high, so the frame restarts in that case as well.
    assign sync_set = bus.SYNC & ~rst;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        sr0_d       = sr0_q;
        sr1_d       = sr1_q;
        value0_d    = value0_q;
        value1_d    = value1_q;
        chmode0_d   = chmode0_q;
        chmode1_d   = chmode1_q;
        frame_cnt_d = frame_cnt_q;
        fmt_err_d   = fmt_err_q;
        word0       = {sr0_q, bus.SDATA[0]};
        word1       = {sr1_q, bus.SDATA[1]};

        unique case (state_q)
            SHIFT: begin
                sr0_d    = {sr0_q[13:0], bus.SDATA[0]};
                sr1_d    = {sr1_q[13:0], bus.SDATA[1]};
                bitcnt_d = bitcnt_q + 4'd1;
                if (bitcnt_q == 4'd15) begin
                    // 16th bit: both lanes commit together on this edge.
                    state_d     = DONE;
                    bitcnt_d    = '0;
                    value0_d    = word0[11:0];
                    value1_d    = word1[11:0];
                    chmode0_d   = word0[13:12];
                    chmode1_d   = word1[13:12];
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if ((|word0[15:14]) || (|word1[15:14])) begin
                        fmt_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Registered decodes keep busy/enabled free of decode glitches.
        enabled_d = {chmode1_d == 2'b00, chmode0_d == 2'b00};
        busy_d    = (state_d == SHIFT);
    end

    always_ff @(negedge SCLK or posedge rst or posedge sync_set) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            sr0_q    <= '0;
            sr1_q    <= '0;
            busy_q   <= 1'b0;
        end else if (sync_set) begin
            state_q  <= SHIFT;
            bitcnt_q <= '0;
            sr0_q    <= '0;
            sr1_q    <= '0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sr0_q    <= sr0_d;
            sr1_q    <= sr1_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(negedge SCLK or posedge rst) begin
        if (rst) begin
            value0_q    <= '0;
            value1_q    <= '0;
            chmode0_q   <= 2'b00;
            chmode1_q   <= 2'b00;
            enabled_q   <= 2'b11;
            frame_cnt_q <= '0;
            fmt_err_q   <= 1'b0;
        end else if (!sync_set) begin
            value0_q    <= value0_d;
            value1_q    <= value1_d;
            chmode0_q   <= chmode0_d;
            chmode1_q   <= chmode1_d;
            enabled_q   <= enabled_d;
            frame_cnt_q <= frame_cnt_d;
            fmt_err_q   <= fmt_err_d;
        end
    end

    // Clocked by SYNC itself: state_q/bitcnt_q still hold their pre-edge
    // values here, which is what decides whether a partial frame was cut.
    always_ff @(posedge bus.SYNC or posedge rst) begin
        if (rst) begin
            abort_cnt_q <= '0;
        end else if ((state_q == SHIFT) && (bitcnt_q != 4'd0) &&
                     (abort_cnt_q != 4'd15)) begin
            abort_cnt_q <= abort_cnt_q + 4'd1;
        end
    end

    assign bus.value0    = value0_q;
    assign bus.value1    = value1_q;
    assign bus.chmode0   = chmode0_q;
    assign bus.chmode1   = chmode1_q;
    assign bus.enabled   = enabled_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.abort_cnt = abort_cnt_q;
    assign bus.fmt_err   = fmt_err_q;

endmodule
